// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO holding fetched {instr, pc} pairs for decode.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_clear,
  input  logic [ENTRY_W-1:0] i_entry,
  output logic [ENTRY_W-1:0] o_head,
  output logic               o_valid,
  output logic [1:0]         o_count
);

  fetch_entry_t r_mem [2];
  logic         r_head;
  logic [1:0]   r_count;
  logic         w_tail;

  // With two slots the tail is head + count mod 2; when full that is the
  // head slot itself, which is exactly where a same-cycle pop+push lands.
  assign w_tail = r_head ^ r_count[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_head  <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_push) r_mem[w_tail] <= fetch_entry_t'(i_entry);
      if (i_pop)  r_head <= ~r_head;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_head  = o_valid ? ENTRY_W'(r_mem[r_head]) : '0;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, fetch buffer and redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic [31:0] PC_F,
  input  logic [31:0] Instr_F,
  input  logic        BranchTaken_E,
  input  logic [31:0] BranchTarget_E,
  output logic        Valid_D,
  input  logic        Ready_D,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus8_D
);

  logic [31:0]        r_pc;
  logic [1:0]         w_count;
  logic               w_pop;
  logic               w_push;
  logic               w_has_room;
  fetch_entry_t       w_push_entry;
  fetch_entry_t       w_head;
  logic [ENTRY_W-1:0] w_head_bits;

  // A redirect masks Ready_D, so the head is neither consumed nor counted.
  assign w_pop      = Valid_D & Ready_D & ~BranchTaken_E;
  assign w_has_room = (w_count < 2'(BUF_DEPTH));
  assign w_push     = ~BranchTaken_E & (w_has_room | w_pop);

  assign w_push_entry.instr = Instr_F;
  assign w_push_entry.pc    = r_pc;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pc <= RESET_PC;
    end else if (BranchTaken_E) begin
      r_pc <= BranchTarget_E & 32'hFFFF_FFFC;
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  fetch_buffer u_buf (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (BranchTaken_E),
    .i_entry (w_push_entry),
    .o_head  (w_head_bits),
    .o_valid (Valid_D),
    .o_count (w_count)
  );

  assign w_head    = fetch_entry_t'(w_head_bits);
  assign PC_F      = r_pc;
  assign Instr_D   = w_head.instr;
  assign PC_D      = w_head.pc;
  assign PCPlus8_D = w_head.pc + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed checks.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [31:0] PC_F;
  logic [31:0] Instr_F;
  logic        BranchTaken_E = 1'b0;
  logic [31:0] BranchTarget_E = 32'h0;
  logic        Valid_D;
  logic        Ready_D = 1'b1;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PCPlus8_D;

  logic        rst2 = 1'b1;
  logic [31:0] pcf2;
  logic [31:0] instr2;
  logic        br2 = 1'b0;
  logic [31:0] tgt2 = 32'h0;
  logic        valid2;
  logic        ready2 = 1'b1;
  logic [31:0] id2;
  logic [31:0] pcd2;
  logic [31:0] p82;

  logic [31:0] mem [64];

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  assign Instr_F = mem[PC_F[7:2]];
  assign instr2  = mem[pcf2[7:2]];

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .PC_F(PC_F), .Instr_F(Instr_F),
    .BranchTaken_E(BranchTaken_E), .BranchTarget_E(BranchTarget_E),
    .Valid_D(Valid_D), .Ready_D(Ready_D), .Instr_D(Instr_D),
    .PC_D(PC_D), .PCPlus8_D(PCPlus8_D)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_dut_hi (
    .CLK(CLK), .RESET_N(rst2), .PC_F(pcf2), .Instr_F(instr2),
    .BranchTaken_E(br2), .BranchTarget_E(tgt2),
    .Valid_D(valid2), .Ready_D(ready2), .Instr_D(id2),
    .PC_D(pcd2), .PCPlus8_D(p82)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference model: a queue of fetched entries and the next fetch address.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ment_t;

  ment_t       q[$];
  logic [31:0] mpc = 32'h0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      q.delete();
      mpc = 32'h0;
    end else if (BranchTaken_E) begin
      q.delete();
      mpc = BranchTarget_E & 32'hFFFF_FFFC;
    end else begin
      if (q.size() > 0 && Ready_D) void'(q.pop_front());
      if (q.size() < 2) begin
        q.push_back('{pc: mpc, instr: mem[mpc[7:2]]});
        mpc = mpc + 32'd4;
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    chk("cyc_pc_f", PC_F, mpc);
    if (q.size() > 0) begin
      chk("cyc_valid", {31'b0, Valid_D}, 32'd1);
      chk("cyc_instr_d", Instr_D, q[0].instr);
      chk("cyc_pc_d", PC_D, q[0].pc);
      chk("cyc_pcplus8", PCPlus8_D, q[0].pc + 32'd8);
    end else begin
      chk("cyc_valid", {31'b0, Valid_D}, 32'd0);
      chk("cyc_instr_d", Instr_D, 32'h0);
      chk("cyc_pc_d", PC_D, 32'h0);
      chk("cyc_pcplus8", PCPlus8_D, 32'h8);
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0101);
    #1;
    RESET_N = 1'b0;
    rst2    = 1'b0;

    // Reset state, then streaming with Ready_D held high
    repeat (2) @(negedge CLK);
    chk("rst_valid", {31'b0, Valid_D}, 32'd0);
    chk("rst_pc_d", PC_D, 32'h0);
    chk("rst_instr_d", Instr_D, 32'h0);
    chk("rst_pcplus8", PCPlus8_D, 32'h8);
    chk("rst_pc_f", PC_F, 32'h0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    chk("s1_valid", {31'b0, Valid_D}, 32'd1);
    chk("s1_pc_d", PC_D, 32'h0);
    chk("s1_instr_d", Instr_D, mem[0]);
    chk("s1_pcplus8", PCPlus8_D, 32'h8);
    for (int i = 1; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("s1_seq_pc_d", PC_D, 32'(i * 4));
      chk("s1_seq_pcplus8", PCPlus8_D, 32'(i * 4 + 8));
    end

    // Stall from reset: buffer fills with PCs 0 and 4, PC_F holds at 8
    @(negedge CLK);
    RESET_N = 1'b0;
    Ready_D = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("stall_pc_f", PC_F, 32'h8);
    chk("stall_pc_d", PC_D, 32'h0);
    @(negedge CLK);
    Ready_D = 1'b1;
    #1;
    chk("rel_pc_d0", PC_D, 32'h0);
    @(posedge CLK); #1;
    chk("rel_pc_d4", PC_D, 32'h4);
    @(posedge CLK); #1;
    chk("rel_pc_d8", PC_D, 32'h8);

    // Redirect while full and stalled
    @(negedge CLK);
    Ready_D = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    BranchTaken_E  = 1'b1;
    BranchTarget_E = 32'h0000_0023;
    @(posedge CLK); #1;
    chk("br_valid", {31'b0, Valid_D}, 32'd0);
    chk("br_pc_f", PC_F, 32'h20);
    @(negedge CLK);
    BranchTaken_E = 1'b0;
    Ready_D       = 1'b1;
    @(posedge CLK); #1;
    chk("br_pc_d", PC_D, 32'h20);
    chk("br_instr_d", Instr_D, mem[8]);

    // Redirect to 0 with a valid head and Ready_D high
    @(negedge CLK);
    BranchTaken_E  = 1'b1;
    BranchTarget_E = 32'h0000_0000;
    @(posedge CLK); #1;
    chk("br0_valid", {31'b0, Valid_D}, 32'd0);
    chk("br0_pc_f", PC_F, 32'h0);
    @(negedge CLK);
    BranchTaken_E = 1'b0;
    @(posedge CLK); #1;
    chk("br0_pc_d", PC_D, 32'h0);
    chk("br0_instr_d", Instr_D, mem[0]);

    // Asynchronous reset pulse between edges
    repeat (3) @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("arst_valid", {31'b0, Valid_D}, 32'd0);
    chk("arst_pc_d", PC_D, 32'h0);
    chk("arst_instr_d", Instr_D, 32'h0);
    chk("arst_pcplus8", PCPlus8_D, 32'h8);
    chk("arst_pc_f", PC_F, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    chk("arst_restart_pc_d", PC_D, 32'h0);
    chk("arst_restart_valid", {31'b0, Valid_D}, 32'd1);

    // Wrap-around with RESET_PC near the top of the address space
    @(negedge CLK);
    chk("hi_rst_pc_f", pcf2, 32'hFFFF_FFF8);
    rst2 = 1'b1;
    @(posedge CLK); #1;
    chk("hi_pc_d0", pcd2, 32'hFFFF_FFF8);
    chk("hi_pcplus8_0", p82, 32'h0000_0000);
    chk("hi_instr_d0", id2, mem[62]);
    @(posedge CLK); #1;
    chk("hi_pc_d1", pcd2, 32'hFFFF_FFFC);
    chk("hi_pcplus8_1", p82, 32'h0000_0004);
    @(posedge CLK); #1;
    chk("hi_pc_d2", pcd2, 32'h0000_0000);
    chk("hi_valid2", {31'b0, valid2}, 32'd1);

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
